// File: rtl/warp_scheduler_if.sv
// ============================================================================
// warp_scheduler_if : launch, fetch and issue signals of the warp scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

interface warp_scheduler_if #(
  parameter int NUM_WARPS = 4,
  parameter int ADDR_W    = 8,
  parameter int INST_W    = 32
);
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                 start;
  logic [NUM_WARPS-1:0] warp_mask;
  logic [ADDR_W-1:0]    start_pc;
  logic [ADDR_W-1:0]    inst_addr;
  logic [INST_W-1:0]    inst;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [WW-1:0]        issue_warp;
  logic [3:0]           opcode;
  logic [3:0]           x;
  logic [3:0]           y;
  logic [3:0]           z;
  logic [15:0]          I;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, warp_mask, start_pc, inst, issue_ready,
    output inst_addr, issue_valid, issue_warp, opcode, x, y, z, I, busy, done
  );

  modport slave (
    output start, warp_mask, start_pc, inst, issue_ready,
    input  inst_addr, issue_valid, issue_warp, opcode, x, y, z, I, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/warp_scheduler.sv
// ============================================================================
// warp_scheduler : round-robin multi-warp fetch/decode/issue front end
// Revision 1.0
// ============================================================================
`default_nettype none

module warp_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int ADDR_W    = 8,
  parameter int INST_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  warp_scheduler_if.master     bus
);
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam logic [3:0] c_OP_HALT = 4'hF;
  localparam logic [3:0] c_OP_JMP  = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE} state_t;

  state_t               r_state, w_state_n;
  logic [ADDR_W-1:0]    r_pc [NUM_WARPS];
  logic [NUM_WARPS-1:0] r_active, w_active_n;
  logic [WW-1:0]        r_rr, w_rr_n;
  logic [WW-1:0]        r_cur, w_cur_n;
  logic                 r_done, w_done_n;
  logic [3:0]           r_opcode, r_x, r_y, r_z;
  logic [15:0]          r_imm;
  logic [WW-1:0]        r_issue_warp;

  logic                 w_load_all, w_pc_wr, w_latch, w_do_pick;
  logic [ADDR_W-1:0]    w_pc_wdata;
  logic [NUM_WARPS-1:0] w_pick_mask;
  logic [WW-1:0]        w_pick_start, w_cur_inc;
  logic [WW:0]          w_pick;
  logic [3:0]           w_op;

  // First active warp at or after s, wrapping modulo NUM_WARPS; MSB = found.
  function automatic logic [WW:0] f_pick(input logic [NUM_WARPS-1:0] m,
                                         input logic [WW-1:0] s);
    logic [WW:0] r;
    int          k;
    r = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      k = (int'(s) + i) % NUM_WARPS;
      if (m[k]) r = {1'b1, WW'(k)};
    end
    return r;
  endfunction

  assign w_op      = bus.inst[31:28];
  assign w_cur_inc = (r_cur == WW'(NUM_WARPS - 1)) ? '0 : r_cur + 1'b1;

  always_comb begin
    w_state_n    = r_state;
    w_active_n   = r_active;
    w_rr_n       = r_rr;
    w_cur_n      = r_cur;
    w_done_n     = r_done;
    w_load_all   = 1'b0;
    w_pc_wr      = 1'b0;
    w_pc_wdata   = r_pc[r_cur];
    w_latch      = 1'b0;
    w_do_pick    = 1'b0;
    w_pick_mask  = r_active;
    w_pick_start = w_cur_inc;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.warp_mask != '0) begin
            w_active_n   = bus.warp_mask;
            w_load_all   = 1'b1;
            w_rr_n       = '0;
            w_done_n     = 1'b0;
            w_do_pick    = 1'b1;
            w_pick_mask  = bus.warp_mask;
            w_pick_start = '0;
          end else begin
            w_done_n = 1'b1;
          end
        end
      end
      S_FETCH: w_state_n = S_WAIT;
      S_WAIT: begin
        if (w_op == c_OP_HALT) begin
          w_active_n  = r_active & ~(NUM_WARPS'(1) << r_cur);
          w_rr_n      = w_cur_inc;
          w_pick_mask = w_active_n;
          w_do_pick   = 1'b1;
        end else if (w_op == c_OP_JMP) begin
          w_pc_wr    = 1'b1;
          w_pc_wdata = bus.inst[ADDR_W-1:0];
          w_rr_n     = w_cur_inc;
          w_do_pick  = 1'b1;
        end else begin
          w_latch   = 1'b1;
          w_state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.issue_ready) begin
          w_pc_wr    = 1'b1;
          w_pc_wdata = r_pc[r_cur] + ADDR_W'(1);
          w_rr_n     = w_cur_inc;
          w_do_pick  = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_pick = f_pick(w_pick_mask, w_pick_start);
    if (w_do_pick) begin
      if (w_pick[WW]) begin
        w_cur_n   = w_pick[WW-1:0];
        w_state_n = S_FETCH;
      end else begin
        w_state_n = S_IDLE;
        w_done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_active     <= '0;
      r_rr         <= '0;
      r_cur        <= '0;
      r_done       <= 1'b0;
      r_opcode     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_imm        <= '0;
      r_issue_warp <= '0;
      for (int i = 0; i < NUM_WARPS; i++) r_pc[i] <= '0;
    end else begin
      r_state  <= w_state_n;
      r_active <= w_active_n;
      r_rr     <= w_rr_n;
      r_cur    <= w_cur_n;
      r_done   <= w_done_n;
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (w_load_all)
          r_pc[i] <= bus.start_pc;
        else if (w_pc_wr && (r_cur == WW'(i)))
          r_pc[i] <= w_pc_wdata;
      end
      if (w_latch) begin
        r_opcode     <= w_op;
        r_x          <= bus.inst[27:24];
        r_y          <= bus.inst[23:20];
        r_z          <= bus.inst[19:16];
        r_imm        <= bus.inst[15:0];
        r_issue_warp <= r_cur;
      end
    end
  end

  assign bus.inst_addr   = r_pc[r_cur];
  assign bus.issue_valid = (r_state == S_ISSUE);
  assign bus.issue_warp  = r_issue_warp;
  assign bus.opcode      = r_opcode;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.z           = r_z;
  assign bus.I           = r_imm;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
endmodule

`default_nettype wire

// File: doc/warp_scheduler.md
# warp_scheduler

Parametrised multi-warp successor to the single-stream SM scheduler. It holds one program counter per warp and fetches from the synchronous instruction memory (one-cycle read latency) in round-robin order over active warps. It decodes the 4-bit `x`/`y`/`z` register fields and the 16-bit immediate `I`, and issues each instruction to the SM execute stage through a valid/ready handshake. `JMP` and `HALT` are resolved locally and never issued.

## Interface
Parameters:
- `NUM_WARPS`, 4 — number of warps, ≥1
- `ADDR_W`, 8 — instruction memory address width, ≤16
- `INST_W`, 32 — instruction width, ≥32

Ports:
- `clk` in 1 — single clock; all state changes on rising edge
- `reset` in 1 — asynchronous, active-high; clears all state immediately
- `start` in 1 — launch pulse, honoured only in IDLE
- `warp_mask` in NUM_WARPS — warps to activate on `start`
- `start_pc` in ADDR_W — initial PC for every launched warp
- `inst_addr` out ADDR_W — fetch address to instruction memory
- `inst` in INST_W — memory data; valid the cycle after `inst_addr` is presented
- `issue_valid` out 1 — decoded instruction available
- `issue_ready` in 1 — execute stage accepts
- `issue_warp` out $clog2(NUM_WARPS) (min 1) — warp id of the issued instruction
- `opcode` out 4 — `inst[31:28]`
- `x`, `y`, `z` out 4 each — `inst[27:24]`, `[23:20]`, `[19:16]`
- `I` out 16 — `inst[15:0]`
- `busy` out 1 — high when not IDLE
- `done` out 1 — sticky; set when the last active warp halts, cleared by `start` or `reset`

## Operation
- State: `pc[NUM_WARPS]`, `active` mask, round-robin pointer `rr`, current warp `cur`, FSM state in {IDLE, FETCH, WAIT, ISSUE}.
- Opcodes: `4'hF` = HALT, `4'hE` = JMP (target `I[ADDR_W-1:0]`). All other opcodes are issued.
- `inst_addr = pc[cur]` in every state (combinational from registers).
- Warp selection ("pick"): first warp with `active` set, searching `rr`, `rr+1`, … mod NUM_WARPS. If no warp is active, the FSM goes to IDLE and sets `done`.
- IDLE:
  - On `start` with `warp_mask != 0`: `active = warp_mask`, all `pc = start_pc`, `rr = 0`, `done = 0`, pick → FETCH.
  - On `start` with a zero mask: stay IDLE and set `done = 1`.
- FETCH: memory samples `inst_addr` → WAIT.
- WAIT: decode `inst`:
  - HALT: clear `active[cur]`; `rr = cur+1`; pick → FETCH or IDLE.
  - JMP: `pc[cur] = I[ADDR_W-1:0]`; `rr = cur+1`; pick → FETCH.
  - Other: latch fields into output registers → ISSUE.
- ISSUE:
  - `issue_valid = 1` with stable `opcode`/`x`/`y`/`z`/`I`/`issue_warp = cur`.
  - On an edge with `issue_ready = 1`: `pc[cur] = pc[cur]+1` (wraps modulo 2^ADDR_W); `rr = cur+1`; pick → FETCH.
  - While `issue_ready = 0`: hold everything.
- Fairness: one instruction per warp per round. A warp that jumps still yields its turn.
- `start` outside IDLE is ignored. Inactive warps' PCs are never modified.

## Timing
- Reset values: `inst_addr = 0`, `issue_valid = 0`, `issue_warp = 0`, `opcode`/`x`/`y`/`z`/`I` = 0, `busy = 0`, `done = 0`, all PCs 0, `active = 0`, `rr = 0`, `cur = 0`, state IDLE.
- Reset asserted mid-operation abandons any pending issue immediately. `issue_valid` drops asynchronously.
- Latency for ALU-type instructions:
  - `start` edge → `inst_addr` valid in FETCH the next cycle.
  - `issue_valid` rises 2 cycles after FETCH entry.
  - Minimum 3 cycles per issued instruction with `issue_ready` held high.
- JMP and HALT cost 2 cycles (FETCH, WAIT) and produce no issue.
- `issue_valid` never deasserts without a handshake, except on reset.
- `busy` rises the cycle after an accepted `start` and falls the cycle `done` rises.

## Test plan
- **Single warp:** mask=`4'b0001`, `start_pc=0`, memory = {ADD x=1 y=2 z=3 I=7, HALT}, ready=1 → one issue with x=1, y=2, z=3, I=7, warp 0, 3 cycles after start. Then `done=1`, `busy=0`, `pc[0]=1`.
- **Round-robin:** mask=`4'b1011`, 2 ALU instructions then HALT at PCs 0–2 → issue order of warps 0,1,3,0,1,3. Warp 2 is never issued. `done` follows the third HALT.
- **Backpressure:** hold `issue_ready=0` for 5 cycles during ISSUE → `issue_valid` stays 1 and fields stay stable. PC advances exactly once after ready rises.
- **JMP:** warp 0 at PC 4 executes JMP I=26 → no issue, `pc[0]=26`. The next fetch of warp 0 presents `inst_addr=26`.
- **PC wrap:** `start_pc=255` (ADDR_W=8), ALU instruction at 255 → after issue `pc=0` and the next fetch is at address 0.
- **Reset/start:** reset asserted in ISSUE → outputs return to reset values without waiting for a clock edge. `start` pulsed while busy is ignored. `start` with mask=0 → `done=1` and no fetch.
